// File: rtl/ib_fifo_dual_if.sv
// Fetch/decode handshake bundle for the dual-ported instruction buffer.
// The master side is fetch plus decode; the slave side is the FIFO itself.
interface ib_fifo_dual_if #(
  parameter int DATA_W = 65,
  parameter int DEPTH  = 16
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              flush;
  logic              stall;
  logic [1:0]        push_cnt;
  logic [DATA_W-1:0] push_data0;
  logic [DATA_W-1:0] push_data1;
  logic              push_ack;
  logic [1:0]        pop_cnt;
  logic              pop_valid0;
  logic              pop_valid1;
  logic [DATA_W-1:0] pop_data0;
  logic [DATA_W-1:0] pop_data1;
  logic [ADDR_W:0]   count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              almost_full;

  modport master (
    output flush, stall, push_cnt, push_data0, push_data1, pop_cnt,
    input  push_ack, pop_valid0, pop_valid1, pop_data0, pop_data1,
           count, fifo_full, fifo_empty, almost_full
  );

  modport slave (
    input  flush, stall, push_cnt, push_data0, push_data1, pop_cnt,
    output push_ack, pop_valid0, pop_valid1, pop_data0, pop_data1,
           count, fifo_full, fifo_empty, almost_full
  );
endinterface

// File: rtl/ib_fifo_dual.sv
// Two-in/two-out show-ahead instruction buffer between fetch and decode.
// Occupancy is tracked with an explicit counter so every slot is usable.
module ib_fifo_dual #(
  parameter int DATA_W = 65,
  parameter int DEPTH  = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  ib_fifo_dual_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr1;
  logic [ADDR_W-1:0] wr_ptr1;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  free;
  logic [CNT_W-1:0]  np;
  logic [CNT_W-1:0]  pq;
  logic [CNT_W-1:0]  nq;
  logic [CNT_W-1:0]  np_acc;
  logic              push_ok;

  assign rd_ptr1 = rd_ptr + ADDR_W'(1);
  assign wr_ptr1 = wr_ptr + ADDR_W'(1);
  assign free    = CNT_W'(DEPTH) - count_q;

  // Request counts of 3 behave as 2 on both ports.
  always_comb begin
    np = '0;
    case (bus.push_cnt)
      2'd0:    np = '0;
      2'd1:    np = CNT_W'(1);
      default: np = CNT_W'(2);
    endcase
    pq = '0;
    case (bus.pop_cnt)
      2'd0:    pq = '0;
      2'd1:    pq = CNT_W'(1);
      default: pq = CNT_W'(2);
    endcase
  end

  // Space is judged on the start-of-cycle count; a same-cycle pop never helps.
  assign push_ok = (np != '0) && (free >= np) && !bus.flush;
  assign np_acc  = push_ok ? np : '0;

  always_comb begin
    nq = '0;
    if (!bus.stall && !bus.flush) begin
      nq = (pq > count_q) ? count_q : pq;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else if (bus.flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      rd_ptr  <= rd_ptr + ADDR_W'(nq);
      wr_ptr  <= wr_ptr + ADDR_W'(np_acc);
      count_q <= count_q + np_acc - nq;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= bus.push_data0;
      if (np == CNT_W'(2)) begin
        mem[wr_ptr1] <= bus.push_data1;
      end
    end
  end

  assign bus.push_ack    = push_ok;
  assign bus.pop_valid0  = (count_q != '0);
  assign bus.pop_valid1  = (count_q >= CNT_W'(2));
  assign bus.pop_data0   = bus.pop_valid0 ? mem[rd_ptr]  : '0;
  assign bus.pop_data1   = bus.pop_valid1 ? mem[rd_ptr1] : '0;
  assign bus.count       = count_q;
  assign bus.fifo_full   = (count_q == CNT_W'(DEPTH));
  assign bus.fifo_empty  = (count_q == '0);
  assign bus.almost_full = (free < CNT_W'(2));
endmodule

// File: tb/tb_ib_fifo_dual.sv
// Directed bench for ib_fifo_dual: hand-written reset sequence followed by
// a table of per-cycle vectors with hand-computed expectations.
module tb_ib_fifo_dual;
  localparam int DW    = 65;
  localparam int DEPTH = 16;

  typedef struct {
    logic          flush;
    logic          stall;
    logic [1:0]    push_cnt;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    logic [1:0]    pop_cnt;
    logic          exp_ack;
    logic [4:0]    exp_cnt;
    logic          exp_v0;
    logic [DW-1:0] exp_d0;
    logic          exp_v1;
    logic [DW-1:0] exp_d1;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  vec_t vecs[$];

  ib_fifo_dual_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus ();

  ib_fifo_dual #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [4:0] cnt, input logic v0,
                           input logic [DW-1:0] d0, input logic v1, input logic [DW-1:0] d1);
    chk({tag, ".count"}, DW'(bus.count), DW'(cnt));
    chk({tag, ".empty"}, DW'(bus.fifo_empty), DW'(cnt == 5'd0));
    chk({tag, ".full"}, DW'(bus.fifo_full), DW'(cnt == 5'd16));
    chk({tag, ".almost_full"}, DW'(bus.almost_full), DW'((5'd16 - cnt) < 5'd2));
    chk({tag, ".pop_valid0"}, DW'(bus.pop_valid0), DW'(v0));
    chk({tag, ".pop_data0"}, bus.pop_data0, d0);
    chk({tag, ".pop_valid1"}, DW'(bus.pop_valid1), DW'(v1));
    chk({tag, ".pop_data1"}, bus.pop_data1, d1);
  endtask

  task automatic add(input logic fl, input logic st, input logic [1:0] pc,
                     input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic [1:0] qc,
                     input logic ack, input logic [4:0] cnt,
                     input logic v0, input logic [DW-1:0] e0,
                     input logic v1, input logic [DW-1:0] e1);
    vec_t v;
    v.flush = fl; v.stall = st; v.push_cnt = pc; v.d0 = d0; v.d1 = d1; v.pop_cnt = qc;
    v.exp_ack = ack; v.exp_cnt = cnt; v.exp_v0 = v0; v.exp_d0 = e0;
    v.exp_v1 = v1; v.exp_d1 = e1;
    vecs.push_back(v);
  endtask

  // Called just after a rising edge: drive, check push_ack mid-cycle, then check state after the edge.
  task automatic apply(input vec_t v, input string tag);
    bus.flush      = v.flush;
    bus.stall      = v.stall;
    bus.push_cnt   = v.push_cnt;
    bus.push_data0 = v.d0;
    bus.push_data1 = v.d1;
    bus.pop_cnt    = v.pop_cnt;
    #1;
    chk({tag, ".push_ack"}, DW'(bus.push_ack), DW'(v.exp_ack));
    @(posedge clk);
    #1;
    chk_state(tag, v.exp_cnt, v.exp_v0, v.exp_d0, v.exp_v1, v.exp_d1);
  endtask

  initial begin
    vec_t v;
    logic [DW-1:0] big_a;
    checks   = 0;
    failures = 0;
    big_a    = {1'b1, 64'h0000_0000_0000_000A};

    rst_n          = 1'b0;
    bus.flush      = 1'b0;
    bus.stall      = 1'b0;
    bus.push_cnt   = 2'd0;
    bus.push_data0 = '0;
    bus.push_data1 = '0;
    bus.pop_cnt    = 2'd0;
    #3;
    chk("reset.push_ack", DW'(bus.push_ack), '0);
    chk_state("reset", 5'd0, 1'b0, '0, 1'b0, '0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Build up count=7, then pulse reset mid-cycle.
    add(0,0,2'd2,'h10,'h11,2'd0, 1,5'd2, 1,'h10,1,'h11);
    add(0,0,2'd2,'h12,'h13,2'd0, 1,5'd4, 1,'h10,1,'h11);
    add(0,0,2'd2,'h14,'h15,2'd0, 1,5'd6, 1,'h10,1,'h11);
    add(0,0,2'd1,'h16,'h0, 2'd0, 1,5'd7, 1,'h10,1,'h11);
    for (int i = 0; i < 4; i++) apply(vecs[i], $sformatf("pre%0d", i));
    vecs.delete();
    bus.push_cnt = 2'd0;
    #2 rst_n = 1'b0;
    #1;
    chk_state("async_reset", 5'd0, 1'b0, '0, 1'b0, '0);
    #1 rst_n = 1'b1;
    #1;
    v.flush = 0; v.stall = 0; v.push_cnt = 2'd1; v.d0 = 'h1; v.d1 = '0; v.pop_cnt = 2'd0;
    v.exp_ack = 1; v.exp_cnt = 5'd1; v.exp_v0 = 1; v.exp_d0 = 'h1; v.exp_v1 = 0; v.exp_d1 = '0;
    apply(v, "first_push");

    // Main vector table: fill, all-or-nothing, flush, simultaneous push/pop/stall, wrap.
    add(0,0,2'd0,'0,'0,2'd1, 0,5'd0, 0,'0,0,'0);
    for (int i = 0; i < 8; i++)
      add(0,0,2'd2,DW'(2*i),DW'(2*i+1),2'd0, 1,5'(2*(i+1)), 1,'h0,1,'h1);
    add(0,0,2'd2,'h99,'h98,2'd0, 0,5'd16, 1,'h0,1,'h1);
    add(0,0,2'd0,'0,'0,2'd1, 0,5'd15, 1,'h1,1,'h2);
    add(0,0,2'd2,'h50,'h51,2'd0, 0,5'd15, 1,'h1,1,'h2);
    add(0,0,2'd1,'h52,'h0,2'd0, 1,5'd16, 1,'h1,1,'h2);
    add(0,0,2'd0,'0,'0,2'd2, 0,5'd14, 1,'h3,1,'h4);
    add(0,0,2'd0,'0,'0,2'd2, 0,5'd12, 1,'h5,1,'h6);
    add(0,0,2'd0,'0,'0,2'd2, 0,5'd10, 1,'h7,1,'h8);
    add(1,0,2'd2,'h70,'h71,2'd2, 0,5'd0, 0,'0,0,'0);
    add(0,0,2'd1,'h55,'h0,2'd0, 1,5'd1, 1,'h55,0,'0);
    add(0,0,2'd2,'h60,'h61,2'd0, 1,5'd3, 1,'h55,1,'h60);
    add(0,0,2'd2,'h62,'h63,2'd2, 1,5'd3, 1,'h61,1,'h62);
    add(0,1,2'd2,'h64,'h65,2'd2, 1,5'd5, 1,'h61,1,'h62);
    add(0,0,2'd0,'0,'0,2'd2, 0,5'd3, 1,'h63,1,'h64);
    add(0,0,2'd0,'0,'0,2'd2, 0,5'd1, 1,'h65,0,'0);
    add(0,0,2'd3,'h66,'h67,2'd0, 1,5'd3, 1,'h65,1,'h66);
    add(0,0,2'd0,'0,'0,2'd3, 0,5'd1, 1,'h67,0,'0);
    add(0,0,2'd0,'0,'0,2'd2, 0,5'd0, 0,'0,0,'0);
    add(0,0,2'd2,'h70,'h71,2'd0, 1,5'd2, 1,'h70,1,'h71);
    add(0,0,2'd2,'h72,'h73,2'd0, 1,5'd4, 1,'h70,1,'h71);
    add(0,0,2'd2,'h74,'h75,2'd0, 1,5'd6, 1,'h70,1,'h71);
    add(0,0,2'd0,'0,'0,2'd2, 0,5'd4, 1,'h72,1,'h73);
    add(0,0,2'd0,'0,'0,2'd2, 0,5'd2, 1,'h74,1,'h75);
    add(0,0,2'd0,'0,'0,2'd2, 0,5'd0, 0,'0,0,'0);
    add(0,0,2'd2,big_a,'hB,2'd0, 1,5'd2, 1,big_a,1,'hB);
    add(0,0,2'd0,'0,'0,2'd2, 0,5'd0, 0,'0,0,'0);
    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
